// File: rtl/mem_arbiter_rr_if.sv
// rtl/mem_arbiter_rr_if.sv - requester/memory bus bundle for the shared memory port arbiter
interface mem_arbiter_rr_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128
);
  // requester side
  logic [NUM_REQ-1:0]        req_valid_in;
  logic [NUM_REQ-1:0]        req_write_in;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_in;
  logic [NUM_REQ*LINE_W-1:0] req_data_in;
  logic [NUM_REQ-1:0]        grant_out;
  logic [NUM_REQ-1:0]        resp_valid_out;
  logic [LINE_W-1:0]         resp_data_out;
  // memory side
  logic                      mem_req_valid_out;
  logic                      mem_req_ready_in;
  logic                      mem_req_write_out;
  logic [ADDR_W-1:0]         mem_req_addr_out;
  logic [LINE_W-1:0]         mem_req_data_out;
  logic                      mem_resp_valid_in;
  logic [LINE_W-1:0]         mem_resp_data_in;
  // status
  logic                      busy_out;

  // arbiter view
  modport master (
    input  req_valid_in, req_write_in, req_addr_in, req_data_in,
    input  mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
    output grant_out, resp_valid_out, resp_data_out,
    output mem_req_valid_out, mem_req_write_out, mem_req_addr_out, mem_req_data_out,
    output busy_out
  );

  // requester/memory environment view
  modport slave (
    output req_valid_in, req_write_in, req_addr_in, req_data_in,
    output mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
    input  grant_out, resp_valid_out, resp_data_out,
    input  mem_req_valid_out, mem_req_write_out, mem_req_addr_out, mem_req_data_out,
    input  busy_out
  );
endinterface

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-requester round-robin/fixed-priority arbiter for the shared memory port
module mem_arbiter_rr #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128,
  parameter int FIXED_PRIO = 0
) (
  input logic             clk,
  input logic             reset,
  mem_arbiter_rr_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   data_q, data_d;

  logic [IDX_W-1:0]    winner;
  logic [IDX_W-1:0]    rr_idx;
  logic                sel_write;
  logic [ADDR_W-1:0]   sel_addr;
  logic [LINE_W-1:0]   sel_data;
  logic [NUM_REQ-1:0]  owner_oh;

  // Winner pick: highest set index in fixed priority, else first set bit at or above rr_ptr with wrap
  always_comb begin
    winner = '0;
    rr_idx = '0;
    if (FIXED_PRIO != 0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid_in[i]) winner = IDX_W'(i);
      end
    end else begin
      // scan downward so the nearest requester above rr_ptr is written last and wins
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        rr_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (bus.req_valid_in[rr_idx]) winner = rr_idx;
      end
    end
  end

  // Payload of the current winner, captured only in the IDLE decision cycle
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == IDX_W'(i)) begin
        sel_write = bus.req_write_in[i];
        sel_addr  = bus.req_addr_in[i*ADDR_W +: ADDR_W];
        sel_data  = bus.req_data_in[i*LINE_W +: LINE_W];
      end
    end
  end

  // State and capture registers; reset drops any transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  // Next state: arbitrate in IDLE, hold payload through ISSUE, wait for the response in WAIT
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    write_d  = write_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid_in) begin
          state_d = ISSUE;
          owner_d = winner;
          write_d = sel_write;
          addr_d  = sel_addr;
          data_d  = sel_data;
          if (FIXED_PRIO == 0) begin
            rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
          end
        end
      end
      ISSUE: begin
        // a response coinciding with accept is not ours yet and is dropped
        if (bus.mem_req_ready_in) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_resp_valid_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: grant and response strobe go to the owner only, memory payload from the capture registers
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = (owner_q == IDX_W'(i));
    end
    bus.grant_out         = (state_q != IDLE) ? owner_oh : '0;
    bus.resp_valid_out    = (state_q == WAIT && bus.mem_resp_valid_in) ? owner_oh : '0;
    bus.resp_data_out     = bus.mem_resp_data_in;
    bus.mem_req_valid_out = (state_q == ISSUE);
    bus.mem_req_write_out = write_q;
    bus.mem_req_addr_out  = addr_q;
    bus.mem_req_data_out  = data_q;
    bus.busy_out          = (state_q != IDLE);
  end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - randomized self-checking bench for mem_arbiter_rr in both arbitration modes
module tb_mem_arbiter_rr;
  localparam int N = 4;
  localparam int A = 32;
  localparam int L = 128;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_write;
  logic [N*A-1:0] req_addr;
  logic [N*L-1:0] req_data;
  logic           mem_ready;
  logic           mem_resp_valid;
  logic [L-1:0]   mem_resp_data;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: round-robin pointer and the expected owner/payload per instance
  int           rr_ptr_m;
  int           own_rr, own_fp;
  logic         ew_rr, ew_fp;
  logic [A-1:0] ea_rr, ea_fp;
  logic [L-1:0] ed_rr, ed_fp;

  mem_arbiter_rr_if #(.NUM_REQ(N), .ADDR_W(A), .LINE_W(L)) bus_rr ();
  mem_arbiter_rr_if #(.NUM_REQ(N), .ADDR_W(A), .LINE_W(L)) bus_fp ();

  assign bus_rr.req_valid_in      = req_valid;
  assign bus_rr.req_write_in      = req_write;
  assign bus_rr.req_addr_in       = req_addr;
  assign bus_rr.req_data_in       = req_data;
  assign bus_rr.mem_req_ready_in  = mem_ready;
  assign bus_rr.mem_resp_valid_in = mem_resp_valid;
  assign bus_rr.mem_resp_data_in  = mem_resp_data;
  assign bus_fp.req_valid_in      = req_valid;
  assign bus_fp.req_write_in      = req_write;
  assign bus_fp.req_addr_in       = req_addr;
  assign bus_fp.req_data_in       = req_data;
  assign bus_fp.mem_req_ready_in  = mem_ready;
  assign bus_fp.mem_resp_valid_in = mem_resp_valid;
  assign bus_fp.mem_resp_data_in  = mem_resp_data;

  mem_arbiter_rr #(.NUM_REQ(N), .ADDR_W(A), .LINE_W(L), .FIXED_PRIO(0)) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_rr.master)
  );

  mem_arbiter_rr #(.NUM_REQ(N), .ADDR_W(A), .LINE_W(L), .FIXED_PRIO(1)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_fp.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    onehot = N'(1) << i;
  endfunction

  function automatic logic [L-1:0] rand_line();
    rand_line = {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // first requesting index at or after ptr, wrapping
  function automatic int rr_pick(input logic [N-1:0] m, input int ptr);
    rr_pick = -1;
    for (int k = N - 1; k >= 0; k--) begin
      if (((m >> ((ptr + k) % N)) & N'(1)) != '0) rr_pick = (ptr + k) % N;
    end
  endfunction

  // highest requesting index
  function automatic int fp_pick(input logic [N-1:0] m);
    fp_pick = -1;
    for (int i = 0; i < N; i++) begin
      if (((m >> i) & N'(1)) != '0) fp_pick = i;
    end
  endfunction

  task automatic scribble_payload();
    for (int i = 0; i < N; i++) begin
      req_write[i]         = 1'($urandom_range(0, 1));
      req_addr[i*A +: A]   = $urandom;
      req_data[i*L +: L]   = rand_line();
    end
  endtask

  task automatic check_one(input string tag, input logic busy, input logic [N-1:0] grant,
                           input logic mv, input logic mw, input logic [A-1:0] ma,
                           input logic [L-1:0] md, input logic [N-1:0] rv, input logic [L-1:0] rd,
                           input int own, input logic ew, input logic [A-1:0] ea, input logic [L-1:0] ed,
                           input bit e_busy, input bit e_mreq, input bit e_grant, input bit e_resp);
    check({tag, ".busy"}, busy, e_busy);
    check({tag, ".grant"}, grant, e_grant ? onehot(own) : '0);
    check({tag, ".mem_req_valid"}, mv, e_mreq);
    check({tag, ".resp_valid"}, rv, e_resp ? onehot(own) : '0);
    if (e_mreq) begin
      check({tag, ".mem_req_write"}, mw, ew);
      check({tag, ".mem_req_addr"}, ma, ea);
      check({tag, ".mem_req_data"}, md, ed);
    end
    if (e_resp) check({tag, ".resp_data"}, rd, mem_resp_data);
  endtask

  task automatic check_both(input string tag, input bit e_busy, input bit e_mreq,
                            input bit e_grant, input bit e_resp);
    check_one({tag, ".rr"}, bus_rr.busy_out, bus_rr.grant_out, bus_rr.mem_req_valid_out,
              bus_rr.mem_req_write_out, bus_rr.mem_req_addr_out, bus_rr.mem_req_data_out,
              bus_rr.resp_valid_out, bus_rr.resp_data_out, own_rr, ew_rr, ea_rr, ed_rr,
              e_busy, e_mreq, e_grant, e_resp);
    check_one({tag, ".fp"}, bus_fp.busy_out, bus_fp.grant_out, bus_fp.mem_req_valid_out,
              bus_fp.mem_req_write_out, bus_fp.mem_req_addr_out, bus_fp.mem_req_data_out,
              bus_fp.resp_valid_out, bus_fp.resp_data_out, own_fp, ew_fp, ea_fp, ed_fp,
              e_busy, e_mreq, e_grant, e_resp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rr.busy"}, bus_rr.busy_out, 1'b0);
    check({tag, ".rr.grant"}, bus_rr.grant_out, '0);
    check({tag, ".rr.resp_valid"}, bus_rr.resp_valid_out, '0);
    check({tag, ".rr.mem_req_valid"}, bus_rr.mem_req_valid_out, 1'b0);
    check({tag, ".rr.mem_req_write"}, bus_rr.mem_req_write_out, 1'b0);
    check({tag, ".rr.mem_req_addr"}, bus_rr.mem_req_addr_out, '0);
    check({tag, ".rr.mem_req_data"}, bus_rr.mem_req_data_out, '0);
    check({tag, ".fp.busy"}, bus_fp.busy_out, 1'b0);
    check({tag, ".fp.grant"}, bus_fp.grant_out, '0);
    check({tag, ".fp.resp_valid"}, bus_fp.resp_valid_out, '0);
    check({tag, ".fp.mem_req_valid"}, bus_fp.mem_req_valid_out, 1'b0);
    check({tag, ".fp.mem_req_write"}, bus_fp.mem_req_write_out, 1'b0);
    check({tag, ".fp.mem_req_addr"}, bus_fp.mem_req_addr_out, '0);
    check({tag, ".fp.mem_req_data"}, bus_fp.mem_req_data_out, '0);
  endtask

  // called at a negedge with both arbiters idle; returns at the negedge after the response
  task automatic do_txn(input logic [N-1:0] mask, input int ready_wait, input int resp_wait,
                        input bit spur_idle, input bit spur_acc, input logic [L-1:0] rdata,
                        input bit rand_pl);
    req_valid = mask;
    if (rand_pl) scribble_payload();
    mem_ready      = 1'b0;
    mem_resp_valid = spur_idle;
    mem_resp_data  = rand_line();
    #1;
    check_both("idle", 0, 0, 0, 0);
    own_rr   = rr_pick(mask, rr_ptr_m);
    own_fp   = fp_pick(mask);
    rr_ptr_m = (own_rr + 1) % N;
    ew_rr = req_write[own_rr];  ea_rr = req_addr[own_rr*A +: A];  ed_rr = req_data[own_rr*L +: L];
    ew_fp = req_write[own_fp];  ea_fp = req_addr[own_fp*A +: A];  ed_fp = req_data[own_fp*L +: L];
    @(negedge clk);
    for (int i = 0; i <= ready_wait; i++) begin
      mem_ready      = (i == ready_wait);
      mem_resp_valid = spur_acc && (i == ready_wait);
      mem_resp_data  = rand_line();
      if (i > 0) scribble_payload();
      #1;
      check_both("issue", 1, 1, 1, 0);
      @(negedge clk);
    end
    mem_ready = 1'b0;
    for (int j = 0; j <= resp_wait; j++) begin
      mem_resp_valid = (j == resp_wait);
      mem_resp_data  = (j == resp_wait) ? rdata : rand_line();
      #1;
      check_both("wait", 1, 0, 1, j == resp_wait);
      @(negedge clk);
    end
    mem_resp_valid = 1'b0;
  endtask

  task automatic idle_cycle(input bit spur);
    req_valid      = '0;
    mem_ready      = 1'b0;
    mem_resp_valid = spur;
    mem_resp_data  = rand_line();
    #1;
    check_both("idle_gap", 0, 0, 0, 0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
  endtask

  task automatic reset_in_wait();
    req_valid = 4'b0010;
    scribble_payload();
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    req_valid = '0;
    mem_resp_data = '0;
    #1;
    check("pre_reset.rr.busy", bus_rr.busy_out, 1'b1);
    reset = 1'b1;
    #1;
    check_zero("reset_in_wait");
    @(negedge clk);
    reset    = 1'b0;
    rr_ptr_m = 0;
    #1;
    check_zero("after_reset");
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = rand_line();
    #1;
    check_zero("late_resp");
    @(negedge clk);
    mem_resp_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    req_valid      = '0;
    req_write      = '0;
    req_addr       = '0;
    req_data       = '0;
    mem_ready      = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    rr_ptr_m       = 0;
    own_rr = 0; own_fp = 0;
    ew_rr = 1'b0; ea_rr = '0; ed_rr = '0;
    ew_fp = 1'b0; ea_fp = '0; ed_fp = '0;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // single read from icache at 0x1000
    req_write      = '0;
    req_addr       = '0;
    req_addr[31:0] = 32'h0000_1000;
    req_data       = '0;
    do_txn(4'b0001, 0, 1, 0, 0, 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D, 0);
    check("t1.addr_const", ea_rr, 32'h0000_1000);
    idle_cycle(0);

    // all requesters valid: rotation in RR, index 3 every time in fixed priority
    for (int t = 0; t < 8; t++) do_txn(4'b1111, 0, 0, 0, 0, rand_line(), 1);

    // 0 and 1 valid, then only 0 after 1 leaves
    do_txn(4'b0011, 1, 0, 0, 0, rand_line(), 1);
    do_txn(4'b0001, 0, 1, 0, 0, rand_line(), 1);

    // long ready stall while requesters rewrite their payload
    do_txn(4'b0010, 5, 2, 0, 0, rand_line(), 1);

    // spurious responses in IDLE and on the accept cycle
    idle_cycle(1);
    do_txn(4'b0100, 2, 1, 1, 1, rand_line(), 1);

    // reset during WAIT then a late response; RR must restart from 0
    reset_in_wait();
    do_txn(4'b1111, 0, 0, 0, 0, rand_line(), 1);

    // random traffic
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
      do_txn(N'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_line(), 1);
    end
    idle_cycle(0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised N-requester arbiter between the core's cache controllers (icache, dcache, and future prefetcher/ptw ports) and the single shared memory port.
- Selects one requester per transaction, in round-robin or fixed-priority order.
- Forwards the captured request to memory with a valid/ready handshake.
- Holds ownership until memory responds, then routes the response back to the owner only.

Parameters:
- NUM_REQ, 2, number of requesters (≥2); index 0 is icache, index 1 is dcache.
- ADDR_W, 32, request address width.
- LINE_W, 128, cache-line data width.
- FIXED_PRIO, 0, 0 = round-robin; 1 = fixed priority, where the highest index wins.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid_in  in  NUM_REQ  per-requester request valid
- req_write_in  in  NUM_REQ  per-requester write (1) / read (0)
- req_addr_in  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_data_in  in  NUM_REQ*LINE_W  packed write lines
- grant_out  out  NUM_REQ  one-hot owner of the current transaction
- resp_valid_out  out  NUM_REQ  one-cycle response strobe to the owner
- resp_data_out  out  LINE_W  response line, broadcast to all requesters
- mem_req_valid_out  out  1  memory request valid
- mem_req_ready_in  in  1  memory accepts the request
- mem_req_write_out  out  1  captured write flag
- mem_req_addr_out  out  ADDR_W  captured address
- mem_req_data_out  out  LINE_W  captured write line
- mem_resp_valid_in  in  1  memory response valid; given for reads and writes
- mem_resp_data_in  in  LINE_W  memory response line
- busy_out  out  1  transaction in progress (state != IDLE)

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE, owner = 0, rr_ptr = 0.
  - Captured write/addr/data cleared.
  - All outputs 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid_in bit is set, pick winner w.
  - Register owner = w and capture write/addr/data of w.
  - Next state is ISSUE; no output changes in the decision cycle.
  - If no request is pending, stay in IDLE.
- Winner selection:
  - Round-robin: first set bit scanning from rr_ptr upward, with wrap-around modulo NUM_REQ. On grant, rr_ptr = (w+1) mod NUM_REQ.
  - Fixed priority: highest set index wins; rr_ptr is unused.
- ISSUE:
  - mem_req_valid_out = 1; mem_req_* are driven from the capture registers.
  - When mem_req_ready_in = 1, go to WAIT and drop mem_req_valid_out the next cycle.
  - Valid stays asserted and payload stays stable until ready.
- WAIT:
  - When mem_resp_valid_in = 1, resp_valid_out[owner] = 1 combinationally in that cycle and resp_data_out = mem_resp_data_in.
  - Next state is IDLE.
- Outside WAIT:
  - mem_resp_valid_in is ignored and resp_valid_out = 0.
  - resp_data_out = mem_resp_data_in (don't-care).
- grant_out = one-hot(owner) while state is ISSUE or WAIT; 0 in IDLE.
- Requester contract:
  - Hold req_valid/payload until grant_out[i] is seen.
  - Deassert req_valid no later than the cycle after resp_valid_out[i]; otherwise the request is re-arbitrated as a new transaction.
- Minimum latency, request to memory: request seen in IDLE cycle t gives mem_req_valid_out at t+1. Back-to-back transactions have one IDLE cycle between response and next issue.
- A request arriving while busy waits; no preemption; the captured payload is immune to requester changes.
- Simultaneous ready and response in ISSUE: the response is ignored. Memory shall respond ≥1 cycle after accept.
- Round-robin with all requesters continuously requesting grants 0,1,…,NUM_REQ-1,0,… No requester waits more than NUM_REQ-1 transactions.
- Reset mid-transaction returns to IDLE immediately. A late memory response after reset is ignored because state is IDLE.

Test Plan:
1. Reset, then a single read from requester 0, addr 0x1000; ready at the first ISSUE cycle; response 0xCAFE… two cycles later:
   - grant_out = 01 from t+1.
   - mem_req_addr_out = 0x1000.
   - resp_valid_out = 01 for exactly one cycle with matching data.
   - busy_out = 0 afterwards.
2. NUM_REQ=4, round-robin, all four requesters permanently valid, 8 transactions -> owner sequence 0,1,2,3,0,1,2,3.
3. FIXED_PRIO=1, requesters 0 and 1 both valid -> requester 1 is granted first; requester 0 is granted after requester 1 deasserts.
4. mem_req_ready_in held 0 for 5 cycles while requester 1 changes req_addr_in -> mem_req_valid_out stays 1 and mem_req_addr_out keeps the originally captured value; accepted on cycle 6.
5. Spurious mem_resp_valid_in in IDLE and in the ISSUE accept cycle -> no resp_valid_out pulse; the real response in WAIT is delivered once.
6. Assert reset during WAIT, then a memory response arrives the cycle after deassertion -> all outputs 0, state IDLE, response ignored, rr_ptr = 0.
